// File: rtl/mul_div_sequencer_pkg.sv
// Shared definitions for the MULT/DIV sequencer: ALUCon encodings,
// FSM states and the default operand width.
package mul_div_sequencer_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MULT = 4'b0011;
  localparam logic [3:0] ALU_DIV  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring-divide step on the {upper, lower} accumulator.
module mul_div_step
  import mul_div_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) begin
      sum = sum + {1'b0, operand};
    end
    // rem_sh keeps the bit shifted out of rem so the trial compare is exact
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    fits   = rem_sh >= {1'b0, operand};
    diff   = rem_sh[WIDTH-1:0] - operand;
    if (!div) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (fits) begin
      acc_next = {diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// Iterative MULT/DIV sequencer writing HI/LO. Define MULDIV_SIGNED_EN
// for two's-complement operands; default build is MULTU/DIVU.
module mul_div_sequencer
  import mul_div_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUCon,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t             state;
  logic [5:0]         count;
  logic               is_div;
  logic               op_div;
  logic               accept;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  assign accept = start && is_muldiv(ALUCon);
  assign op_div = (ALUCon == ALU_DIV);

`ifdef MULDIV_SIGNED_EN
  logic               sign_a;
  logic               sign_b;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
    prod  = (sign_a ^ sign_b) ? -acc : acc;
    if (is_div) begin
      lo_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0]
                                 : acc[WIDTH-1:0];
      // remainder follows the dividend's sign
      hi_fix = sign_a ? -acc[2*WIDTH-1:WIDTH]
                      : acc[2*WIDTH-1:WIDTH];
    end else begin
      lo_fix = prod[WIDTH-1:0];
      hi_fix = prod[2*WIDTH-1:WIDTH];
    end
  end
`else
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    lo_fix = acc[WIDTH-1:0];
    hi_fix = acc[2*WIDTH-1:WIDTH];
  end
`endif

  mul_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div     (is_div),
    .acc     (acc),
    .operand (operand),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      operand  <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_SIGNED_EN
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            is_div   <= op_div;
            operand  <= op_div ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, op_div ? a_mag : b_mag};
            count    <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= S_CALC;
`ifdef MULDIV_SIGNED_EN
            sign_a   <= a[WIDTH-1];
            sign_b   <= b[WIDTH-1];
`endif
          end
        end
        S_CALC: begin
          acc   <= acc_next;
          count <= count + 6'd1;
          if (count == LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          hi       <= hi_fix;
          lo       <= lo_fix;
          div_zero <= is_div && (operand == '0);
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer; expectations follow
// MULDIV_SIGNED_EN when it is defined.
module tb_mul_div_sequencer;
  import mul_div_sequencer_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  ALUCon;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mul_div_sequencer #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ALUCon  (ALUCon),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic launch(input logic [3:0] op,
                        input logic [31:0] av,
                        input logic [31:0] bv);
    @(negedge clk);
    start  = 1'b1;
    ALUCon = op;
    a      = av;
    b      = bv;
    @(posedge clk);
    #1;
    start  = 1'b0;
    ALUCon = ALU_ADD;
  endtask

  task automatic finish_op(input string name, input int skip,
                           input logic [31:0] eh,
                           input logic [31:0] el,
                           input logic ez);
    int n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 33 - skip) begin
      $display("FAIL %s latency: got %0d want %0d", name, n, 33 - skip);
      errors++;
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      $display("FAIL %s hilo: got %h_%h want %h_%h", name, hi, lo, eh, el);
      errors++;
    end
    checks++;
    if (div_zero !== ez || busy !== 1'b1) begin
      $display("FAIL %s dz/busy: got %b%b want %b1",
               name, div_zero, busy, ez);
      errors++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL %s end: busy %b done %b want 00", name, busy, done);
      errors++;
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    start  = 1'b0;
    ALUCon = ALU_ADD;
    a      = '0;
    b      = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || hi !== 0 || lo !== 0) begin
      $display("FAIL reset: bdz %b%b%b hi %h lo %h want all 0",
               busy, done, div_zero, hi, lo);
      errors++;
    end
  endtask

  task automatic test_mult;
    launch(ALU_MULT, 32'd7, 32'd6);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL mult7x6 accept: busy %b done %b want 10", busy, done);
      errors++;
    end
    finish_op("mult7x6", 0, 32'd0, 32'd42, 1'b0);
    launch(ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef MULDIV_SIGNED_EN
    finish_op("mult_ones", 0, 32'h0, 32'h1, 1'b0);
`else
    finish_op("mult_ones", 0, 32'hFFFF_FFFE, 32'h1, 1'b0);
`endif
  endtask

  task automatic test_div;
    launch(ALU_DIV, 32'd100, 32'd7);
    finish_op("div100_7", 0, 32'd2, 32'd14, 1'b0);
    launch(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
`ifdef MULDIV_SIGNED_EN
    finish_op("div_min", 0, 32'h0, 32'h8000_0000, 1'b0);
    launch(ALU_DIV, -32'sd100, 32'd7);
    finish_op("div_neg", 0, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
`else
    finish_op("div_min", 0, 32'h8000_0000, 32'h0, 1'b0);
`endif
  endtask

  task automatic test_div_zero;
    launch(ALU_DIV, 32'd5, 32'd0);
    finish_op("div_zero", 0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    launch(ALU_MULT, 32'd3, 32'd4);
    checks++;
    if (div_zero !== 1'b0) begin
      $display("FAIL dz_clear: got %b want 0", div_zero);
      errors++;
    end
    finish_op("mult3x4", 0, 32'd0, 32'd12, 1'b0);
  endtask

  task automatic test_ignored_op;
    @(negedge clk);
    start  = 1'b1;
    ALUCon = 4'b0010;
    a      = 32'd9;
    b      = 32'd9;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        $display("FAIL ignored_op cyc%0d: busy %b done %b want 00",
                 i, busy, done);
        errors++;
      end
    end
    start = 1'b0;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      $display("FAIL ignored_op hilo: got %h_%h want 0_c", hi, lo);
      errors++;
    end
  endtask

  task automatic test_start_while_busy;
    launch(ALU_MULT, 32'd9, 32'd11);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start  = 1'b1;
    ALUCon = ALU_DIV;
    a      = 32'd1000;
    b      = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    start  = 1'b0;
    ALUCon = ALU_ADD;
    finish_op("busy_start", 7, 32'd0, 32'd99, 1'b0);
  endtask

  task automatic test_back_to_back;
    launch(ALU_DIV, 32'd100, 32'd7);
    repeat (33) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL b2b done: got %b want 1", done);
      errors++;
    end
    @(negedge clk);
    start  = 1'b1;
    ALUCon = ALU_MULT;
    a      = 32'd2;
    b      = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
      $display("FAIL done_start: busy %b hilo %h_%h want 0 2_e",
               busy, hi, lo);
      errors++;
    end
    launch(ALU_MULT, 32'h0000_FFFF, 32'h0001_0001);
    finish_op("b2b_mult", 0, 32'h0, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_reset_mid;
    launch(ALU_MULT, 32'd1000, 32'd1000);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 0 || lo !== 0) begin
      $display("FAIL reset_mid: busy %b done %b hilo %h_%h want 0 0 0_0",
               busy, done, hi, lo);
      errors++;
    end
    launch(ALU_MULT, 32'd123, 32'd456);
    finish_op("after_reset", 0, 32'd0, 32'd56088, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignored_op();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
